// File: rtl/sel_arbiter.sv
// sel_arbiter: round-robin arbiter for two requesters driving a 2:1 mux select.
// Each grant lasts at most HOLD_CYCLES cycles, so neither source can starve the
// other. All outputs come straight from flops, so downstream logic sees clean,
// glitch-free control.
// Optional feature: define SEL_ARBITER_LOCK_EN to add a 'lock' input. While
// lock is high, the current owner keeps the path past tenure expiry.
module sel_arbiter #(
    parameter int HOLD_CYCLES = 4,
    parameter int CW          = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_a,
    input  logic          req_b,
`ifdef SEL_ARBITER_LOCK_EN
    input  logic          lock,
`endif
    output logic          sel,
    output logic          gnt_a,
    output logic          gnt_b,
    output logic [CW-1:0] hold_cnt
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_A = 2'd1,
        GRANT_B = 2'd2
    } state_t;

    // A fresh tenure counts down from HOLD_CYCLES-1 to 0 (HOLD_CYCLES cycles total).
    localparam logic [CW-1:0] RELOAD = CW'(HOLD_CYCLES - 1);

    state_t        state;
    state_t        state_nxt;
    logic          last_b;
    logic          last_b_nxt;
    logic          sel_nxt;
    logic          gnt_a_nxt;
    logic          gnt_b_nxt;
    logic [CW-1:0] cnt_nxt;
    logic          keep_owner;

    // Decide whether the current owner may keep the path once its tenure has expired.
`ifdef SEL_ARBITER_LOCK_EN
    assign keep_owner = lock;
`else
    assign keep_owner = 1'b0;
`endif

    // Next-state logic. Registered outputs are computed here, so every flop updates together.
    always_comb begin
        state_nxt  = state;
        last_b_nxt = last_b;
        sel_nxt    = sel;
        cnt_nxt    = hold_cnt;
        gnt_a_nxt  = 1'b0;
        gnt_b_nxt  = 1'b0;

        unique case (state)
            IDLE: begin
                if (req_a && (!req_b || last_b)) begin
                    state_nxt  = GRANT_A;
                    cnt_nxt    = RELOAD;
                    sel_nxt    = 1'b0;
                    last_b_nxt = 1'b0;
                end else if (req_b) begin
                    state_nxt  = GRANT_B;
                    cnt_nxt    = RELOAD;
                    sel_nxt    = 1'b1;
                    last_b_nxt = 1'b1;
                end
            end
            GRANT_A: begin
                if (!req_a) begin
                    if (req_b) begin
                        state_nxt  = GRANT_B;
                        cnt_nxt    = RELOAD;
                        sel_nxt    = 1'b1;
                        last_b_nxt = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end
                end else if (hold_cnt != '0) begin
                    cnt_nxt = hold_cnt - 1'b1;
                end else if (keep_owner) begin
                    cnt_nxt = '0;
                end else if (req_b) begin
                    state_nxt  = GRANT_B;
                    cnt_nxt    = RELOAD;
                    sel_nxt    = 1'b1;
                    last_b_nxt = 1'b1;
                end else begin
                    cnt_nxt = RELOAD;
                end
            end
            GRANT_B: begin
                if (!req_b) begin
                    if (req_a) begin
                        state_nxt  = GRANT_A;
                        cnt_nxt    = RELOAD;
                        sel_nxt    = 1'b0;
                        last_b_nxt = 1'b0;
                    end else begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end
                end else if (hold_cnt != '0) begin
                    cnt_nxt = hold_cnt - 1'b1;
                end else if (keep_owner) begin
                    cnt_nxt = '0;
                end else if (req_a) begin
                    state_nxt  = GRANT_A;
                    cnt_nxt    = RELOAD;
                    sel_nxt    = 1'b0;
                    last_b_nxt = 1'b0;
                end else begin
                    cnt_nxt = RELOAD;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase

        gnt_a_nxt = (state_nxt == GRANT_A);
        gnt_b_nxt = (state_nxt == GRANT_B);
    end

    // State and output registers. Reset sets the last-served pointer to B, so A wins the first tie.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            last_b   <= 1'b1;
            sel      <= 1'b0;
            gnt_a    <= 1'b0;
            gnt_b    <= 1'b0;
            hold_cnt <= '0;
        end else begin
            state    <= state_nxt;
            last_b   <= last_b_nxt;
            sel      <= sel_nxt;
            gnt_a    <= gnt_a_nxt;
            gnt_b    <= gnt_b_nxt;
            hold_cnt <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_sel_arbiter.sv
// tb_sel_arbiter: directed testbench for sel_arbiter (HOLD_CYCLES=4, CW=8).
// Define SEL_ARBITER_LOCK_EN to also exercise the lock input.
module tb_sel_arbiter;

    logic       clk;
    logic       rst_n;
    logic       req_a;
    logic       req_b;
`ifdef SEL_ARBITER_LOCK_EN
    logic       lock;
`endif
    logic       sel;
    logic       gnt_a;
    logic       gnt_b;
    logic [7:0] hold_cnt;

    int errors = 0;
    int checks = 0;

    sel_arbiter #(.HOLD_CYCLES(4), .CW(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_a    (req_a),
        .req_b    (req_b),
`ifdef SEL_ARBITER_LOCK_EN
        .lock     (lock),
`endif
        .sel      (sel),
        .gnt_a    (gnt_a),
        .gnt_b    (gnt_b),
        .hold_cnt (hold_cnt)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle 1 ns before anything is sampled.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Put the DUT back into reset for one edge with all requests low.
    task automatic do_reset();
        rst_n = 1'b0;
        req_a = 1'b0;
        req_b = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    // Hold reset for two edges with both sources requesting; then A wins the first tie.
    task automatic test_reset();
        rst_n = 1'b0;
        req_a = 1'b1;
        req_b = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if ({gnt_a, gnt_b, sel, hold_cnt} !== {3'b000, 8'd0}) begin
                errors++;
                $display("[TB] FAIL reset_hold cyc=%0d got ga=%b gb=%b sel=%b cnt=%0d want 0 0 0 0",
                         i, gnt_a, gnt_b, sel, hold_cnt);
            end
        end
        rst_n = 1'b1;
        step();
        checks++;
        if ({gnt_a, gnt_b, sel, hold_cnt} !== {3'b100, 8'd3}) begin
            errors++;
            $display("[TB] FAIL reset_release got ga=%b gb=%b sel=%b cnt=%0d want 1 0 0 3",
                     gnt_a, gnt_b, sel, hold_cnt);
        end
    endtask

    // A lone requester keeps the path; its tenure reloads each time it expires.
    task automatic test_single();
        logic [7:0] exp_cnt;
        do_reset();
        req_a = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            exp_cnt = 8'(3 - (i % 4));
            checks++;
            if ({gnt_a, gnt_b, sel, hold_cnt} !== {3'b100, exp_cnt}) begin
                errors++;
                $display("[TB] FAIL single cyc=%0d got ga=%b gb=%b sel=%b cnt=%0d want 1 0 0 %0d",
                         i, gnt_a, gnt_b, sel, hold_cnt, exp_cnt);
            end
        end
    endtask

    // Under constant contention, ownership alternates every four cycles.
    task automatic test_contention();
        logic [7:0] exp_cnt;
        logic       exp_b;
        do_reset();
        req_a = 1'b1;
        req_b = 1'b1;
        for (int i = 0; i < 16; i++) begin
            step();
            exp_cnt = 8'(3 - (i % 4));
            exp_b   = ((i / 4) % 2) == 1;
            checks++;
            if ({gnt_a, gnt_b, sel, hold_cnt} !== {~exp_b, exp_b, exp_b, exp_cnt}) begin
                errors++;
                $display("[TB] FAIL contention cyc=%0d got ga=%b gb=%b sel=%b cnt=%0d want %b %b %b %0d",
                         i, gnt_a, gnt_b, sel, hold_cnt, ~exp_b, exp_b, exp_b, exp_cnt);
            end
        end
    endtask

    // When the owner drops, the waiting source takes over with no idle bubble.
    // After both drop, the arbiter idles and sel keeps its last value.
    task automatic test_early_release();
        do_reset();
        req_a = 1'b1;
        step();
        step();
        checks++;
        if ({gnt_a, gnt_b, sel, hold_cnt} !== {3'b100, 8'd2}) begin
            errors++;
            $display("[TB] FAIL early_setup got ga=%b gb=%b sel=%b cnt=%0d want 1 0 0 2",
                     gnt_a, gnt_b, sel, hold_cnt);
        end
        req_a = 1'b0;
        req_b = 1'b1;
        step();
        checks++;
        if ({gnt_a, gnt_b, sel, hold_cnt} !== {3'b011, 8'd3}) begin
            errors++;
            $display("[TB] FAIL early_switch got ga=%b gb=%b sel=%b cnt=%0d want 0 1 1 3",
                     gnt_a, gnt_b, sel, hold_cnt);
        end
        req_b = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if ({gnt_a, gnt_b, sel, hold_cnt} !== {3'b001, 8'd0}) begin
                errors++;
                $display("[TB] FAIL early_idle cyc=%0d got ga=%b gb=%b sel=%b cnt=%0d want 0 0 1 0",
                         i, gnt_a, gnt_b, sel, hold_cnt);
            end
        end
    endtask

    // Reset in the middle of a B grant clears everything; A wins the next tie.
    task automatic test_mid_reset();
        do_reset();
        req_b = 1'b1;
        step();
        step();
        step();
        checks++;
        if ({gnt_a, gnt_b, sel, hold_cnt} !== {3'b011, 8'd1}) begin
            errors++;
            $display("[TB] FAIL midrst_setup got ga=%b gb=%b sel=%b cnt=%0d want 0 1 1 1",
                     gnt_a, gnt_b, sel, hold_cnt);
        end
        rst_n = 1'b0;
        req_a = 1'b1;
        step();
        checks++;
        if ({gnt_a, gnt_b, sel, hold_cnt} !== {3'b000, 8'd0}) begin
            errors++;
            $display("[TB] FAIL midrst_clear got ga=%b gb=%b sel=%b cnt=%0d want 0 0 0 0",
                     gnt_a, gnt_b, sel, hold_cnt);
        end
        rst_n = 1'b1;
        step();
        checks++;
        if ({gnt_a, gnt_b, sel, hold_cnt} !== {3'b100, 8'd3}) begin
            errors++;
            $display("[TB] FAIL midrst_first got ga=%b gb=%b sel=%b cnt=%0d want 1 0 0 3",
                     gnt_a, gnt_b, sel, hold_cnt);
        end
    endtask

    // After A is served and the arbiter idles, B wins the next tie.
    task automatic test_pointer();
        do_reset();
        req_a = 1'b1;
        step();
        req_a = 1'b0;
        step();
        checks++;
        if ({gnt_a, gnt_b, sel, hold_cnt} !== {3'b000, 8'd0}) begin
            errors++;
            $display("[TB] FAIL pointer_idle got ga=%b gb=%b sel=%b cnt=%0d want 0 0 0 0",
                     gnt_a, gnt_b, sel, hold_cnt);
        end
        req_a = 1'b1;
        req_b = 1'b1;
        step();
        checks++;
        if ({gnt_a, gnt_b, sel, hold_cnt} !== {3'b011, 8'd3}) begin
            errors++;
            $display("[TB] FAIL pointer_tie got ga=%b gb=%b sel=%b cnt=%0d want 0 1 1 3",
                     gnt_a, gnt_b, sel, hold_cnt);
        end
    endtask

`ifdef SEL_ARBITER_LOCK_EN
    // With lock high, A keeps the path and the counter sticks at 0; when lock drops, B takes over.
    task automatic test_lock();
        logic [7:0] exp_cnt;
        do_reset();
        lock  = 1'b1;
        req_a = 1'b1;
        req_b = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            exp_cnt = (i < 4) ? 8'(3 - i) : 8'd0;
            checks++;
            if ({gnt_a, gnt_b, sel, hold_cnt} !== {3'b100, exp_cnt}) begin
                errors++;
                $display("[TB] FAIL lock_hold cyc=%0d got ga=%b gb=%b sel=%b cnt=%0d want 1 0 0 %0d",
                         i, gnt_a, gnt_b, sel, hold_cnt, exp_cnt);
            end
        end
        lock = 1'b0;
        step();
        checks++;
        if ({gnt_a, gnt_b, sel, hold_cnt} !== {3'b011, 8'd3}) begin
            errors++;
            $display("[TB] FAIL lock_release got ga=%b gb=%b sel=%b cnt=%0d want 0 1 1 3",
                     gnt_a, gnt_b, sel, hold_cnt);
        end
    endtask
`endif

    // Run the scenarios in order, then print the summary.
    initial begin
        rst_n = 1'b0;
        req_a = 1'b0;
        req_b = 1'b0;
`ifdef SEL_ARBITER_LOCK_EN
        lock  = 1'b0;
`endif
        #1;
        test_reset();
        test_single();
        test_contention();
        test_early_release();
        test_mid_reset();
        test_pointer();
`ifdef SEL_ARBITER_LOCK_EN
        test_lock();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sel_arbiter.md
Name: sel_arbiter

Overview:
- Upstream control stage for the 2:1 select mux (sel=0 passes a, sel=1 passes b).
- Arbitrates two requesters (A, B) round-robin and drives the mux select from registered state.
- Each grant has a bounded tenure of HOLD_CYCLES cycles, so one source cannot starve the other.
- All outputs are registered, so downstream combinational select logic sees glitch-free control.

Parameters:
- HOLD_CYCLES, 4, grant tenure in clock cycles; legal range 1..2**CW.
- CW, 8, width of tenure counter and hold_cnt output.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous reset, active-low.
- req_a  input  1  source A requests the mux path.
- req_b  input  1  source B requests the mux path.
- sel  output  1  mux select; 0 = A, 1 = B.
- gnt_a  output  1  A currently owns the path.
- gnt_b  output  1  B currently owns the path.
- hold_cnt  output  CW  remaining tenure cycles of the current grant; 0 when idle.

Behaviour:
- Interface (already decided):
  - One clock, clk.
  - Reset rst_n is synchronous and active-low, sampled on the rising edge of clk.
- Reset values:
  - state=IDLE, sel=0, gnt_a=0, gnt_b=0, hold_cnt=0.
  - last-served pointer = B, so A wins the first tie.
- Reset timing:
  - Reset mid-grant takes effect at the next edge with rst_n=0.
  - Reset overrides all requests; outputs reach reset values after that edge.
- Latency:
  - Requests are sampled at edge k; the resulting grant/sel are visible after edge k.
  - One-cycle request-to-grant latency.
- Output encoding:
  - gnt_a/gnt_b are one-hot or both zero.
  - sel=1 only in GRANT_B, sel=0 in GRANT_A.
  - In IDLE, sel holds its last value; no toggle without a grant.
- States: IDLE, GRANT_A, GRANT_B.
- IDLE:
  - req_a&req_b → grant the source that is not last-served.
  - Only one request → grant it.
  - None → stay IDLE.
  - On any grant: hold_cnt loads HOLD_CYCLES-1 and the pointer updates to the granted source.
- GRANT_X (X = requester owning the path, Y = the other):
  - !req_X, req_Y → switch directly to GRANT_Y; no idle bubble; hold_cnt reloads.
  - !req_X, !req_Y → IDLE, hold_cnt=0.
  - req_X, hold_cnt==0, req_Y → switch to GRANT_Y, reload.
  - req_X, hold_cnt==0, !req_Y → stay in GRANT_X, reload (new tenure).
  - req_X, hold_cnt>0 → stay, hold_cnt decrements by 1.
- Arithmetic:
  - Counter is unsigned CW bits and never wraps; decrements stop at 0.
  - HOLD_CYCLES=1 gives alternation every cycle under constant contention.
- Simultaneous events:
  - Owner drop has priority over tenure expiry.
  - Requests arriving in the same cycle as a release are arbitrated in that cycle.

Optional Feature:
- Macro: SEL_ARBITER_LOCK_EN.
- Defined:
  - Adds input port lock (1 bit).
  - While in GRANT_X with req_X=1 and lock=1, tenure expiry is ignored: hold_cnt stays at 0 and the grant is kept.
  - Releasing req_X still releases the grant regardless of lock.
- Undefined:
  - No lock port.
  - Tenure expiry always behaves as in Behaviour.

Test Plan:
- Reset: rst_n=0 for 2 cycles with req_a=req_b=1 → sel=0, gnt_a=0, gnt_b=0, hold_cnt=0 throughout; first edge after release gives gnt_a=1, hold_cnt=3.
- Single requester: req_a=1 held 10 cycles, HOLD_CYCLES=4 → gnt_a stays 1; hold_cnt sequence 3,2,1,0,3,2,1,0,3,2.
- Contention: req_a=req_b=1 constant → A for 4 cycles (sel=0), then B for 4 cycles (sel=1), alternating; gnt never both 1.
- Early release: A granted, hold_cnt=2, req_a drops with req_b=1 → next edge gnt_b=1, sel=1, hold_cnt=3, no idle cycle; then both drop → IDLE, sel stays 1, hold_cnt=0.
- Mid-operation reset: GRANT_B with hold_cnt=1, rst_n=0 one cycle → all outputs reset; with both requesting afterwards, A wins first.
- Lock (SEL_ARBITER_LOCK_EN): A granted, lock=1, req_b=1 for 12 cycles → gnt_a held and hold_cnt pinned at 0 after 4 cycles; lock=0 → B granted on the next edge.
